rga_bus_decoder: RTL

Parametrised, registered decoder for the Denise register-address (RGA) bus. Samples RGA address and data once per colour clock, classifies the access into register groups with a channel index, emits one-clock write strobes with held data, and sequences the read path (output drive plus clear-after-read for CLXDAT). It sits between the chip-bus pins and the bitplane, sprite, collision, colour and joystick units, generalising the fixed single-cycle enable decoder with channel counts, an AGA mode, a read sequencer and an unmapped-access counter.

---
 rtl/rga_pkg.sv | 40 ++++
 rtl/rga_read_seq.sv | 59 +++++
 rtl/rga_bus_decoder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/rga_pkg.sv
// Shared constants for the Denise RGA bus decoder: register addresses (rga[8:1]),
// strobe group indices, read-source encodings and sequencer states.
package rga_pkg;

   localparam logic [7:0] RGA_IDLE     = 8'hFF;
   localparam logic [7:0] RGA_JOY0DAT  = 8'h05;
   localparam logic [7:0] RGA_JOY1DAT  = 8'h06;
   localparam logic [7:0] RGA_CLXDAT   = 8'h07;
   localparam logic [7:0] RGA_DENISEID = 8'h3E;
   localparam logic [7:0] RGA_DIWSTRT  = 8'h47;
   localparam logic [7:0] RGA_DIWSTOP  = 8'h48;
   localparam logic [7:0] RGA_CLXCON   = 8'h4C;
   localparam logic [7:0] RGA_BPLCON4  = 8'h86;
   localparam logic [7:0] RGA_CLXCON2  = 8'h87;

   localparam int GRP_W      = 10;
   localparam int GRP_BPLCON = 0;
   localparam int GRP_BPLDAT = 1;
   localparam int GRP_SPRPOS = 2;
   localparam int GRP_SPRCTL = 3;
   localparam int GRP_SPRDTA = 4;
   localparam int GRP_SPRDTB = 5;
   localparam int GRP_COLOR  = 6;
   localparam int GRP_CLXCON = 7;
   localparam int GRP_DIW    = 8;
   localparam int GRP_READ   = 9;

   typedef enum logic [1:0] {
      RD_CLXDAT   = 2'd0,
      RD_JOY0DAT  = 2'd1,
      RD_JOY1DAT  = 2'd2,
      RD_DENISEID = 2'd3
   } rd_sel_e;

   typedef enum logic {
      SEQ_IDLE  = 1'b0,
      SEQ_DRIVE = 1'b1
   } seq_state_e;

endpackage

// File: rtl/rga_read_seq.sv
// Read-path sequencer: holds drive_en from a decoded read until the next cck_en,
// and pulses clx_clear when a finished (or superseded) read was CLXDAT.
module rga_read_seq
   import rga_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    cck_en_i,
   input  logic    rd_start_i,
   input  rd_sel_e rd_sel_i,
   output logic    drive_en_o,
   output logic    clx_clear_o
);

   seq_state_e state_q, state_d;
   logic       clx_pend_q, clx_pend_d;
   logic       clx_clear_q, clx_clear_d;
   logic       finish_s;

   // Next-state: a new read always (re)enters DRIVE; a restart still retires the pending clear.
   always_comb begin
      state_d     = state_q;
      clx_pend_d  = clx_pend_q;
      clx_clear_d = 1'b0;
      finish_s    = (state_q == SEQ_DRIVE) && (cck_en_i || rd_start_i);
      if (finish_s) begin
         clx_clear_d = clx_pend_q;
      end else begin
         clx_clear_d = 1'b0;
      end
      if (rd_start_i) begin
         state_d    = SEQ_DRIVE;
         clx_pend_d = (rd_sel_i == RD_CLXDAT);
      end else if (finish_s) begin
         state_d    = SEQ_IDLE;
         clx_pend_d = 1'b0;
      end else begin
         state_d    = state_q;
         clx_pend_d = clx_pend_q;
      end
   end

   // Sequencer state register; reset abandons a pending clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= SEQ_IDLE;
         clx_pend_q  <= 1'b0;
         clx_clear_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clx_pend_q  <= clx_pend_d;
         clx_clear_q <= clx_clear_d;
      end
   end

   assign drive_en_o  = (state_q == SEQ_DRIVE);
   assign clx_clear_o = clx_clear_q;

endmodule

// File: rtl/rga_bus_decoder.sv
// Registered RGA bus decoder: stage 1 captures rga/data on cck_en, stage 2 decodes
// into one-hot group strobes with channel index, held data and read sequencing.
module rga_bus_decoder
   import rga_pkg::*;
#(
   parameter int NUM_SPR = 8,
   parameter int NUM_BPL = 6,
   parameter bit AGA_EN  = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cck_en,
   input  logic [7:0]        rga,
   input  logic [15:0]       data_in,
   output logic [GRP_W-1:0]  grp_strb,
   output logic [4:0]        chan,
   output logic [15:0]       wdata,
   output logic [1:0]        rd_sel,
   output logic              drive_en,
   output logic              clx_clear,
   output logic [7:0]        unmapped_cnt
);

   localparam int BPL_MAX = AGA_EN ? 8 : 6;
   localparam int BPL_LIM = (NUM_BPL < BPL_MAX) ? NUM_BPL : BPL_MAX;

   logic [7:0]       addr_q;
   logic [15:0]      data_q;
   logic             hit_s, unmapped_s, rd_start_s;
   logic [3:0]       grp_s;
   logic [4:0]       chan_s;
   rd_sel_e          rd_s;
   logic [GRP_W-1:0] grp_strb_q, grp_strb_d;
   logic [4:0]       chan_q, chan_d;
   logic [15:0]      wdata_q, wdata_d;
   logic [1:0]       rd_sel_q, rd_sel_d;
   logic [7:0]       cnt_q, cnt_d;

   // Stage 1: without a cck_en the address falls back to idle so each access decodes once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q <= RGA_IDLE;
         data_q <= 16'h0000;
      end else if (cck_en) begin
         addr_q <= rga;
         data_q <= data_in;
      end else begin
         addr_q <= RGA_IDLE;
         data_q <= data_q;
      end
   end

   // Address classification; disabled channels and AGA-only registers drop out as misses.
   always_comb begin
      hit_s  = 1'b1;
      grp_s  = 4'(GRP_BPLCON);
      chan_s = 5'd0;
      rd_s   = RD_CLXDAT;
      if (addr_q == RGA_IDLE) begin
         hit_s = 1'b0;
      end else if (addr_q[7:2] == 6'b100000) begin
         chan_s = {3'd0, addr_q[1:0]};
      end else if (AGA_EN && (addr_q == RGA_BPLCON4)) begin
         chan_s = 5'd4;
      end else if (addr_q[7:3] == 5'b10001) begin
         grp_s  = 4'(GRP_BPLDAT);
         chan_s = {2'd0, addr_q[2:0]};
         hit_s  = (int'(addr_q[2:0]) < BPL_LIM);
      end else if (addr_q[7:5] == 3'b101) begin
         grp_s  = 4'(GRP_SPRPOS) + {2'd0, addr_q[1:0]};
         chan_s = {2'd0, addr_q[4:2]};
         hit_s  = (int'(addr_q[4:2]) < NUM_SPR);
      end else if (addr_q[7:5] == 3'b110) begin
         grp_s  = 4'(GRP_COLOR);
         chan_s = addr_q[4:0];
      end else if (addr_q == RGA_CLXCON) begin
         grp_s  = 4'(GRP_CLXCON);
      end else if (AGA_EN && (addr_q == RGA_CLXCON2)) begin
         grp_s  = 4'(GRP_CLXCON);
         chan_s = 5'd1;
      end else if (addr_q == RGA_DIWSTRT) begin
         grp_s  = 4'(GRP_DIW);
      end else if (addr_q == RGA_DIWSTOP) begin
         grp_s  = 4'(GRP_DIW);
         chan_s = 5'd1;
      end else begin
         grp_s = 4'(GRP_READ);
         case (addr_q)
            RGA_CLXDAT:   rd_s = RD_CLXDAT;
            RGA_JOY0DAT:  rd_s = RD_JOY0DAT;
            RGA_JOY1DAT:  rd_s = RD_JOY1DAT;
            RGA_DENISEID: rd_s = RD_DENISEID;
            default:      hit_s = 1'b0;
         endcase
      end
   end

   assign unmapped_s = !hit_s && (addr_q != RGA_IDLE);
   assign rd_start_s = hit_s && (grp_s == 4'(GRP_READ));

   // Stage-2 next values: chan/wdata/rd_sel only move on a strobe, counter saturates.
   always_comb begin
      grp_strb_d = hit_s ? (10'd1 << grp_s) : 10'd0;
      chan_d     = hit_s ? chan_s : chan_q;
      wdata_d    = hit_s ? data_q : wdata_q;
      rd_sel_d   = rd_start_s ? rd_s : rd_sel_q;
      if (unmapped_s && (cnt_q != 8'hFF)) begin
         cnt_d = cnt_q + 8'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Stage-2 output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grp_strb_q <= 10'd0;
         chan_q     <= 5'd0;
         wdata_q    <= 16'h0000;
         rd_sel_q   <= 2'd0;
         cnt_q      <= 8'd0;
      end else begin
         grp_strb_q <= grp_strb_d;
         chan_q     <= chan_d;
         wdata_q    <= wdata_d;
         rd_sel_q   <= rd_sel_d;
         cnt_q      <= cnt_d;
      end
   end

   rga_read_seq u_read_seq (
      .clk         (clk),
      .reset       (reset),
      .cck_en_i    (cck_en),
      .rd_start_i  (rd_start_s),
      .rd_sel_i    (rd_s),
      .drive_en_o  (drive_en),
      .clx_clear_o (clx_clear)
   );

   assign grp_strb     = grp_strb_q;
   assign chan         = chan_q;
   assign wdata        = wdata_q;
   assign rd_sel       = rd_sel_q;
   assign unmapped_cnt = cnt_q;

endmodule
